inst_decode_queue: RTL and testbench

INST_DECODE_QUEUE -- requirements
Module: inst_decode_queue

---
 rtl/inst_decode_queue_pkg.sv | 18 +
 rtl/inst_decode_queue_checker.sv | 30 +++
 rtl/inst_decode_queue_popcount.sv | 27 ++
 rtl/inst_decode_queue.sv | 132 +++++++++++++
 tb/tb_inst_decode_queue.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/inst_decode_queue_pkg.sv
// ----------------------------------------------------------------------------
// inst_decode_queue_pkg
// Shared front-end sizing for the fetch -> decode instruction queue.
// Holds the default fetch/issue widths, queue depth and PC width used by
// the decode wrapper, next to the ROB sizing it already carries.
// ----------------------------------------------------------------------------
package inst_decode_queue_pkg;

  localparam int DEF_FETCH_WIDTH     = 2;
  localparam int DEF_ISSUE_WIDTH     = 2;
  localparam int DEF_IDQ_DEPTH       = 8;
  localparam int DEF_INST_ADDR_WIDTH = 32;
  localparam int ROB_SIZE_WIDTH      = 5;

  // Instruction word width is fixed by the ISA.
  localparam int INST_WIDTH = 32;

endpackage

// File: rtl/inst_decode_queue_checker.sv
// ----------------------------------------------------------------------------
// inst_decode_queue_checker
// Protocol checks for the instruction decode queue. Decode must never
// consume more entries than are being presented on out_valid.
// Ports:
//   clk, reset  - clock and async active-high reset
//   stall/flush - dequeue suppressors (check is skipped while either is set)
//   deq_count   - entries consumed by decode this cycle
//   occupancy   - registered queue fill level
// ----------------------------------------------------------------------------
module inst_decode_queue_checker #(
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH       = 8
) (
  input logic                             clk,
  input logic                             reset,
  input logic                             stall,
  input logic                             flush,
  input logic [$clog2(ISSUE_WIDTH+1)-1:0] deq_count,
  input logic [$clog2(DEPTH+1)-1:0]       occupancy
);

  // Presented lanes = min(occupancy, ISSUE_WIDTH); an empty queue ignores deq_count.
  a_deq_within_presented : assert property (
    @(posedge clk) disable iff (reset)
    (!stall && !flush && (occupancy != '0)) |->
      ((32'(deq_count) <= 32'(occupancy)) && (32'(deq_count) <= ISSUE_WIDTH))
  );

endmodule

// File: rtl/inst_decode_queue_popcount.sv
// ----------------------------------------------------------------------------
// idq_popcount
// Counts the set bits of a lane-valid mask.
// Ports:
//   mask  - per-lane valid bits
//   count - number of set bits in mask
// ----------------------------------------------------------------------------
module idq_popcount
  import inst_decode_queue_pkg::*;
#(
  parameter int WIDTH = DEF_FETCH_WIDTH
) (
  input  logic [WIDTH-1:0]               mask,
  output logic [$clog2(WIDTH+1)-1:0]     count
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  // Accumulate one per set lane bit
  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CNT_W'(mask[i]);
    end
  end

endmodule

// File: rtl/inst_decode_queue.sv
// ----------------------------------------------------------------------------
// inst_decode_queue
// Circular instruction queue between fetch and decode/rename. Fetch writes
// up to FETCH_WIDTH contiguous lanes per cycle when a whole group fits;
// decode sees the ISSUE_WIDTH oldest entries straight out of storage and
// retires deq_count of them per cycle.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   flush               - drop all queued and incoming instructions
//   in_valid/inst/pc    - fetch group, valid lanes contiguous from lane 0
//   in_ready            - a full fetch group fits this cycle
//   out_valid/inst/pc   - oldest entries, lane 0 oldest
//   deq_count           - entries consumed by decode this cycle
//   stall               - rename back-pressure, forces dequeue to zero
//   occupancy           - registered number of valid entries
// ----------------------------------------------------------------------------
module inst_decode_queue
  import inst_decode_queue_pkg::*;
#(
  parameter int FETCH_WIDTH     = DEF_FETCH_WIDTH,
  parameter int ISSUE_WIDTH     = DEF_ISSUE_WIDTH,
  parameter int DEPTH           = DEF_IDQ_DEPTH,
  parameter int INST_ADDR_WIDTH = DEF_INST_ADDR_WIDTH
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         flush,
  input  logic [FETCH_WIDTH-1:0]                       in_valid,
  input  logic [FETCH_WIDTH-1:0][INST_WIDTH-1:0]       in_inst,
  input  logic [FETCH_WIDTH-1:0][INST_ADDR_WIDTH-1:0]  in_pc,
  output logic                                         in_ready,
  output logic [ISSUE_WIDTH-1:0]                       out_valid,
  output logic [ISSUE_WIDTH-1:0][INST_WIDTH-1:0]       out_inst,
  output logic [ISSUE_WIDTH-1:0][INST_ADDR_WIDTH-1:0]  out_pc,
  input  logic [$clog2(ISSUE_WIDTH+1)-1:0]             deq_count,
  input  logic                                         stall,
  output logic [$clog2(DEPTH+1)-1:0]                   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int DEQ_W = $clog2(ISSUE_WIDTH + 1);
  localparam int ENQ_W = $clog2(FETCH_WIDTH + 1);

  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [OCC_W-1:0] occ_r;

  logic [ENQ_W-1:0] in_popcount_s;
  logic             enq_go_s;
  logic [ENQ_W-1:0] enq_cnt_s;
  logic [DEQ_W-1:0] deq_eff_s;

  // Storage is deliberately not reset; out_valid masks stale entries.
  logic [INST_WIDTH-1:0]      inst_mem_r [DEPTH];
  logic [INST_ADDR_WIDTH-1:0] pc_mem_r   [DEPTH];

  idq_popcount #(
    .WIDTH (FETCH_WIDTH)
  ) u_popcount (
    .mask  (in_valid),
    .count (in_popcount_s)
  );

  // Ready depends only on registered fill level, never on this cycle's dequeue.
  assign in_ready  = (occ_r <= OCC_W'(DEPTH - FETCH_WIDTH));
  assign occupancy = occ_r;

  // Effective enqueue/dequeue amounts; flush wins over everything, empty ignores deq_count
  always_comb begin
    enq_go_s = in_ready & ~flush;
    if (enq_go_s) begin
      enq_cnt_s = in_popcount_s;
    end else begin
      enq_cnt_s = '0;
    end
    if (stall || flush || (occ_r == '0)) begin
      deq_eff_s = '0;
    end else begin
      deq_eff_s = deq_count;
    end
  end

  // Head, tail and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_r <= '0;
      tail_r <= '0;
      occ_r  <= '0;
    end else if (flush) begin
      head_r <= '0;
      tail_r <= '0;
      occ_r  <= '0;
    end else begin
      head_r <= head_r + PTR_W'(deq_eff_s);
      tail_r <= tail_r + PTR_W'(enq_cnt_s);
      occ_r  <= occ_r + OCC_W'(enq_cnt_s) - OCC_W'(deq_eff_s);
    end
  end

  // Lane i of an accepted fetch group lands at tail + i
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (enq_go_s && in_valid[i]) begin
        inst_mem_r[tail_r + PTR_W'(i)] <= in_inst[i];
        pc_mem_r[tail_r + PTR_W'(i)]   <= in_pc[i];
      end
    end
  end

  // Decode lanes read straight from storage at head + i (no extra pipeline stage)
  for (genvar g = 0; g < ISSUE_WIDTH; g++) begin : g_rd
    logic [PTR_W-1:0] rd_idx_s;
    assign rd_idx_s     = head_r + PTR_W'(g);
    assign out_inst[g]  = inst_mem_r[rd_idx_s];
    assign out_pc[g]    = pc_mem_r[rd_idx_s];
    assign out_valid[g] = (OCC_W'(g) < occ_r);
  end

  inst_decode_queue_checker #(
    .ISSUE_WIDTH (ISSUE_WIDTH),
    .DEPTH       (DEPTH)
  ) u_checker (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .flush     (flush),
    .deq_count (deq_count),
    .occupancy (occ_r)
  );

endmodule

// File: tb/tb_inst_decode_queue.sv
// ----------------------------------------------------------------------------
// tb_inst_decode_queue
// Directed bench for inst_decode_queue with FETCH_WIDTH=2, ISSUE_WIDTH=2,
// DEPTH=8, 32-bit PCs. Instruction words are derived from their PC so any
// reordering or loss shows up on out_inst as well as out_pc.
// ----------------------------------------------------------------------------
module tb_inst_decode_queue;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic [1:0]       in_valid;
  logic [1:0][31:0] in_inst;
  logic [1:0][31:0] in_pc;
  logic             in_ready;
  logic [1:0]       out_valid;
  logic [1:0][31:0] out_inst;
  logic [1:0][31:0] out_pc;
  logic [1:0]       deq_count;
  logic             stall;
  logic [3:0]       occupancy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  inst_decode_queue #(
    .FETCH_WIDTH     (2),
    .ISSUE_WIDTH     (2),
    .DEPTH           (8),
    .INST_ADDR_WIDTH (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_inst   (in_inst),
    .in_pc     (in_pc),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_inst  (out_inst),
    .out_pc    (out_pc),
    .deq_count (deq_count),
    .stall     (stall),
    .occupancy (occupancy)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'hA5A5_0000 ^ pc;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a fetch group at pc, pc+4 and the dequeue request
  task automatic grp(input logic [1:0] v, input logic [31:0] pc, input logic [1:0] dq);
    in_valid   = v;
    in_pc[0]   = pc;
    in_pc[1]   = pc + 32'd4;
    in_inst[0] = inst_of(pc);
    in_inst[1] = inst_of(pc + 32'd4);
    deq_count  = dq;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    stall     = 1'b0;
    in_valid  = 2'b00;
    in_inst   = '0;
    in_pc     = '0;
    deq_count = 2'd0;

    // Reset state
    #2;
    chk("rst_occ",      64'(occupancy), 64'd0);
    chk("rst_out_valid",64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready),  64'd1);
    tick();
    reset = 1'b0;

    // First fetch group; nothing visible in the same cycle
    in_valid   = 2'b11;
    in_inst[0] = 32'h0050_0093;
    in_inst[1] = 32'h0010_0113;
    in_pc[0]   = 32'h0;
    in_pc[1]   = 32'h4;
    deq_count  = 2'd0;
    #1;
    chk("nobypass_valid", 64'(out_valid), 64'd0);
    tick();
    chk("first_occ",   64'(occupancy),   64'd2);
    chk("first_valid", 64'(out_valid),   64'h3);
    chk("first_pc0",   64'(out_pc[0]),   64'h0);
    chk("first_pc1",   64'(out_pc[1]),   64'h4);
    chk("first_inst0", 64'(out_inst[0]), 64'h0050_0093);
    chk("first_inst1", 64'(out_inst[1]), 64'h0010_0113);

    // Fill under stall (deq_count ignored)
    stall = 1'b1;
    for (int g = 1; g < 4; g++) begin
      grp(2'b11, 32'(8 * g), 2'd2);
      tick();
      chk("fill_occ", 64'(occupancy), 64'(2 + 2 * g));
    end
    chk("full_ready", 64'(in_ready),  64'd0);
    chk("full_valid", 64'(out_valid), 64'h3);
    grp(2'b11, 32'h20, 2'd2);
    tick();
    chk("drop_occ", 64'(occupancy), 64'd8);
    chk("drop_pc0", 64'(out_pc[0]), 64'h0);

    // Drain two, upstream still holds the 0x20 group
    stall = 1'b0;
    grp(2'b00, 32'h20, 2'd2);
    tick();
    chk("drain_occ",   64'(occupancy),   64'd6);
    chk("drain_pc0",   64'(out_pc[0]),   64'h8);
    chk("drain_inst0", 64'(out_inst[0]), 64'(inst_of(32'h8)));
    chk("drain_ready", 64'(in_ready),    64'd1);

    // Steady stream: 2 in / 2 out for 10 cycles, pointers wrap
    for (int k = 0; k < 10; k++) begin
      grp(2'b11, 32'(32'h20 + 8 * k), 2'd2);
      tick();
      chk("wrap_occ",   64'(occupancy),   64'd6);
      chk("wrap_ready", 64'(in_ready),    64'd1);
      chk("wrap_pc0",   64'(out_pc[0]),   64'(32'h10 + 8 * k));
      chk("wrap_pc1",   64'(out_pc[1]),   64'(32'h14 + 8 * k));
      chk("wrap_inst1", 64'(out_inst[1]), 64'(inst_of(32'(32'h14 + 8 * k))));
    end

    // Down to 3 entries: 0x64, 0x68, 0x6C
    grp(2'b00, 32'h0, 2'd2);
    tick();
    grp(2'b00, 32'h0, 2'd1);
    tick();
    chk("pre_part_occ", 64'(occupancy), 64'd3);
    chk("pre_part_pc0", 64'(out_pc[0]), 64'h64);

    // Partial group (one lane) with deq 2
    grp(2'b01, 32'h70, 2'd2);
    in_pc[1] = 32'hDEAD_BEEF;
    tick();
    chk("part_occ",   64'(occupancy),   64'd2);
    chk("part_valid", 64'(out_valid),   64'h3);
    chk("part_pc0",   64'(out_pc[0]),   64'h6C);
    chk("part_pc1",   64'(out_pc[1]),   64'h70);
    chk("part_inst1", 64'(out_inst[1]), 64'(inst_of(32'h70)));

    // Build up to 6 then flush with incoming group and dequeue
    grp(2'b11, 32'h74, 2'd0);
    tick();
    grp(2'b11, 32'h7C, 2'd0);
    tick();
    chk("pre_flush_occ", 64'(occupancy), 64'd6);
    flush = 1'b1;
    stall = 1'b1;
    grp(2'b11, 32'h84, 2'd1);
    tick();
    flush = 1'b0;
    stall = 1'b0;
    chk("flush_occ",   64'(occupancy), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ready", 64'(in_ready),  64'd1);

    // Empty queue ignores deq_count
    grp(2'b00, 32'h0, 2'd2);
    tick();
    chk("empty_deq_occ", 64'(occupancy), 64'd0);

    // Post-flush enqueue lands at lane 0
    grp(2'b11, 32'h90, 2'd0);
    tick();
    chk("postflush_occ", 64'(occupancy), 64'd2);
    chk("postflush_pc0", 64'(out_pc[0]), 64'h90);

    // Reach occupancy 5, then async reset mid-cycle
    grp(2'b11, 32'h98, 2'd0);
    tick();
    grp(2'b11, 32'hA0, 2'd0);
    tick();
    grp(2'b00, 32'h0, 2'd1);
    tick();
    chk("pre_rst_occ", 64'(occupancy), 64'd5);
    chk("pre_rst_pc0", 64'(out_pc[0]), 64'h94);
    grp(2'b00, 32'h0, 2'd0);
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_occ",   64'(occupancy), 64'd0);
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_ready", 64'(in_ready),  64'd1);
    tick();
    reset = 1'b0;

    // First enqueue after reset release
    grp(2'b01, 32'h200, 2'd0);
    #1;
    chk("rel_nobypass", 64'(out_valid), 64'd0);
    tick();
    chk("rel_occ",   64'(occupancy),   64'd1);
    chk("rel_valid", 64'(out_valid),   64'h1);
    chk("rel_pc0",   64'(out_pc[0]),   64'h200);
    chk("rel_inst0", 64'(out_inst[0]), 64'(inst_of(32'h200)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
